// File: rtl/fetch_align.sv
// fetch_align
//   Turns a stream of 32-bit memory words into aligned 16/32-bit instructions.
//   Instructions may start on any halfword, and a 32-bit instruction may
//   straddle two memory words. Up to three halfwords are buffered.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset (beats flush and handshakes)
//   flush_i        redirect request; drops the same-cycle word and handshake
//   flush_pc_i     redirect target (halfword aligned, bit 0 ignored)
//   fetch_addr_o   word address the memory should present next
//   mem_valid_i    memory word for fetch_addr_o is present
//   mem_rdata_i    memory word
//   mem_ready_o    word is accepted this cycle
//   instr_o        aligned instruction (zero-extended when 16-bit)
//   pc_o           address of instr_o
//   compressed_o   instr_o is a 16-bit instruction
//   instr_valid_o  instr_o/pc_o/compressed_o are valid
//   instr_ready_i  downstream takes the instruction this cycle
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] fetch_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_ready_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        compressed_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    // Halfword buffer, entry 0 (oldest) in bits [15:0].
    logic [47:0] buf_reg;
    logic [47:0] buf_next;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic [31:0] pc_reg;
    logic [31:0] fetch_addr_reg;
    logic        skip_reg;

    logic        compressed;
    logic        take;
    logic        accept;
    logic [1:0]  cons_n;
    logic [1:0]  rem;
    logic [47:0] shifted;

    assign compressed    = buf_reg[1:0] != 2'b11;
    assign instr_valid_o = ((count_reg != 2'd0) && compressed) || (count_reg >= 2'd2);
    assign take          = instr_valid_o && instr_ready_i;

    // Halfwords removed by the output handshake this cycle.
    assign cons_n = take ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    assign rem    = count_reg - cons_n;

    // A word may carry two halfwords, so accept only when at most one entry
    // survives the consume; this keeps the buffer within three entries even
    // when a single compressed instruction leaves from a full buffer.
    assign mem_ready_o = !flush_i && (rem <= 2'd1);
    assign accept      = mem_valid_i && mem_ready_o;

    // Consume first: survivors move down to entry 0.
    assign shifted = buf_reg >> {cons_n, 4'b0000};

    // New halfwords land directly after the surviving remainder.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_entry
            logic sel_lo;
            logic sel_hi;
            assign sel_lo = accept && !skip_reg && (rem == 2'(gi));
            assign sel_hi = accept && (skip_reg ? (rem == 2'(gi))
                                                : (({1'b0, rem} + 3'd1) == 3'(gi)));
            assign buf_next[16*gi +: 16] = sel_lo ? mem_rdata_i[15:0]  :
                                           sel_hi ? mem_rdata_i[31:16] :
                                                    shifted[16*gi +: 16];
        end
    endgenerate

    assign count_next = rem + (accept ? (skip_reg ? 2'd1 : 2'd2) : 2'd0);

    // Buffer contents are qualified by count_reg, so they need no reset.
    always_ff @(posedge clk_i) begin
        buf_reg <= buf_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg      <= 2'd0;
            pc_reg         <= {RESET_PC[31:1], 1'b0};
            fetch_addr_reg <= {RESET_PC[31:2], 2'b00};
            skip_reg       <= RESET_PC[1];
        end else if (flush_i) begin
            count_reg      <= 2'd0;
            pc_reg         <= {flush_pc_i[31:1], 1'b0};
            fetch_addr_reg <= {flush_pc_i[31:2], 2'b00};
            // Target in the upper half: the lower half of the first word is dropped.
            skip_reg       <= flush_pc_i[1];
        end else begin
            count_reg <= count_next;
            if (take) begin
                pc_reg <= pc_reg + (compressed ? 32'd2 : 32'd4);
            end
            if (accept) begin
                fetch_addr_reg <= fetch_addr_reg + 32'd4;
                skip_reg       <= 1'b0;
            end
        end
    end

    assign fetch_addr_o = fetch_addr_reg;
    assign pc_o         = pc_reg;
    assign compressed_o = compressed;
    assign instr_o      = compressed ? {16'h0000, buf_reg[15:0]} : buf_reg[31:0];

endmodule

// File: tb/tb_fetch_align.sv
// Testbench for fetch_align: directed scenarios plus randomized streams
// checked against a memory-walking reference model.
module tb_fetch_align;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] fetch_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        compressed_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory image; addresses alias modulo 1 KiB.
    logic [31:0] mem [0:255];

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .fetch_addr_o (fetch_addr_o),
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_o  (mem_ready_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .compressed_o (compressed_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: halfword stored at byte address a.
    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Present inputs for the current cycle (called just after a falling edge).
    task automatic cyc(input logic mv, input logic rdy);
        mem_valid_i   = mv;
        instr_ready_i = rdy;
        mem_rdata_i   = mv ? mem[fetch_addr_o[9:2]] : $urandom();
        #1;
    endtask

    task automatic next_cycle;
        @(negedge clk_i);
        rst_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic do_reset;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        cyc(1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset;
        rst_i      = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0040;
        cyc(1'b1, 1'b1);
        next_cycle();
        cyc(1'b0, 1'b0);
        tests_run++;
        if (instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", instr_valid_o);
        end
        tests_run++;
        if (pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h expected 00000000", pc_o);
        end
        tests_run++;
        if (fetch_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_fetch_addr: got %h expected 00000000", fetch_addr_o);
        end
        tests_run++;
        if (mem_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mem_ready: got %b expected 1", mem_ready_o);
        end
        next_cycle();
    endtask

    task automatic test_word_stream;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        do_reset();
        cyc(1'b1, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b0 || fetch_addr_o !== 32'h0 || mem_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_first: got valid=%b addr=%h ready=%b expected 0/00000000/1",
                     instr_valid_o, fetch_addr_o, mem_ready_o);
        end
        next_cycle();
        cyc(1'b1, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== 32'h0 || compressed_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_instr0: got v=%b %h pc=%h c=%b expected 1 00000013 pc=0 c=0",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0010_0093 || pc_o !== 32'h4 || compressed_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_instr1: got v=%b %h pc=%h c=%b expected 1 00100093 pc=4 c=0",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drained: got valid=%b expected 0", instr_valid_o);
        end
        next_cycle();
    endtask

    task automatic test_compressed_pair;
        mem[0] = 32'h4501_4505;
        do_reset();
        cyc(1'b1, 1'b1);
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4505 || pc_o !== 32'h0 || compressed_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pair_lo: got v=%b %h pc=%h c=%b expected 1 00004505 pc=0 c=1",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4501 || pc_o !== 32'h2 || compressed_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pair_hi: got v=%b %h pc=%h c=%b expected 1 00004501 pc=2 c=1",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
    endtask

    task automatic test_straddle;
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h0000_0010;
        do_reset();
        cyc(1'b1, 1'b1);
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4505 || pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL straddle_first: got v=%b %h pc=%h expected 1 00004505 pc=0",
                     instr_valid_o, instr_o, pc_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL straddle_early: got valid=%b expected 0 before word1", instr_valid_o);
        end
        next_cycle();
        cyc(1'b1, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b0 || mem_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL straddle_accept: got valid=%b ready=%b expected 0/1", instr_valid_o, mem_ready_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0010_0093 || pc_o !== 32'h2 || compressed_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL straddle_instr: got v=%b %h pc=%h c=%b expected 1 00100093 pc=2 c=0",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
    endtask

    task automatic test_flush;
        mem[0]  = 32'h0000_0013;
        mem[64] = 32'hABCD_0001;
        do_reset();
        cyc(1'b1, 1'b0);
        next_cycle();
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0102;
        cyc(1'b1, 1'b1);
        tests_run++;
        if (mem_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_mem_ready: got %b expected 0", mem_ready_o);
        end
        next_cycle();
        cyc(1'b1, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b0 || fetch_addr_o !== 32'h100 || pc_o !== 32'h102) begin
            tests_failed++;
            $display("FAIL flush_state: got v=%b addr=%h pc=%h expected 0 00000100 00000102",
                     instr_valid_o, fetch_addr_o, pc_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_ABCD || pc_o !== 32'h102 || compressed_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_instr: got v=%b %h pc=%h c=%b expected 1 0000abcd pc=102 c=1",
                     instr_valid_o, instr_o, pc_o, compressed_o);
        end
        next_cycle();
    endtask

    task automatic test_stall;
        mem[0] = 32'h0093_1234;
        mem[1] = 32'h4505_0010;
        mem[2] = 32'h00A0_0513;
        do_reset();
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0002;
        cyc(1'b0, 1'b0);
        next_cycle();
        cyc(1'b1, 1'b0);
        next_cycle();
        cyc(1'b1, 1'b0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0);
            tests_run++;
            if (mem_ready_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_o !== 32'h0010_0093 || pc_o !== 32'h2) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got ready=%b v=%b %h pc=%h expected 0 1 00100093 pc=2",
                         c, mem_ready_o, instr_valid_o, instr_o, pc_o);
            end
            next_cycle();
        end
        cyc(1'b1, 1'b1);
        tests_run++;
        if (instr_o !== 32'h0010_0093 || pc_o !== 32'h2 || mem_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got %h pc=%h ready=%b expected 00100093 pc=2 ready=1",
                     instr_o, pc_o, mem_ready_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4505 || pc_o !== 32'h6) begin
            tests_failed++;
            $display("FAIL stall_next: got v=%b %h pc=%h expected 1 00004505 pc=6", instr_valid_o, instr_o, pc_o);
        end
        next_cycle();
        cyc(1'b0, 1'b1);
        tests_run++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h00A0_0513 || pc_o !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_after: got v=%b %h pc=%h expected 1 00a00513 pc=8", instr_valid_o, instr_o, pc_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stream;
        for (int i = 0; i < 4; i++) mem[i] = {$urandom_range(0, 32'h3FFF_FFFF) * 4} | 32'h3;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b1);
            next_cycle();
        end
        rst_i      = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0080;
        cyc(1'b1, 1'b1);
        next_cycle();
        cyc(1'b0, 1'b0);
        tests_run++;
        if (instr_valid_o !== 1'b0 || pc_o !== 32'h0 || fetch_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got v=%b pc=%h addr=%h expected 0 00000000 00000000",
                     instr_valid_o, pc_o, fetch_addr_o);
        end
        next_cycle();
    endtask

    // Sustained stream with both sides always ready: one instruction per cycle.
    task automatic test_back_to_back(input bit use16);
        logic [15:0] h0, h1, exp_hw;
        logic [31:0] exp_pc, exp_instr;
        logic        exp_comp;
        int          first;
        for (int i = 0; i < 64; i++) begin
            h0 = 16'($urandom());
            h1 = 16'($urandom());
            if (use16) begin
                if (h0[1:0] == 2'b11) h0[1:0] = 2'b01;
                if (h1[1:0] == 2'b11) h1[1:0] = 2'b10;
            end else begin
                h0[1:0] = 2'b11;
            end
            mem[i] = {h1, h0};
        end
        do_reset();
        exp_pc = 32'h0;
        first  = -1;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b1, 1'b1);
            if (first < 0 && instr_valid_o) first = c;
            if (first >= 0) begin
                exp_hw    = hw_at(exp_pc);
                exp_comp  = exp_hw[1:0] != 2'b11;
                exp_instr = exp_comp ? {16'h0000, exp_hw} : {hw_at(exp_pc + 32'd2), exp_hw};
                tests_run++;
                if (instr_valid_o !== 1'b1 || instr_o !== exp_instr || pc_o !== exp_pc || compressed_o !== exp_comp) begin
                    tests_failed++;
                    $display("FAIL b2b%0d_cycle%0d: got v=%b %h pc=%h c=%b expected 1 %h pc=%h c=%b",
                             use16, c, instr_valid_o, instr_o, pc_o, compressed_o, exp_instr, exp_pc, exp_comp);
                end
                exp_pc = exp_pc + (exp_comp ? 32'd2 : 32'd4);
            end
            next_cycle();
        end
        tests_run++;
        if (first !== 1) begin
            tests_failed++;
            $display("FAIL b2b%0d_latency: first valid at cycle %0d expected 1", use16, first);
        end
    endtask

    // Random memory, random handshakes, redirects including across 2^32 wrap.
    task automatic test_random(input int iters);
        logic [31:0] start, exp_pc, exp_instr, prev_instr, prev_pc;
        logic [15:0] exp_hw;
        logic        exp_comp, prev_hold;
        int          emitted;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom();
            start = (it == 0) ? (32'hFFFF_FFE0 | (32'($urandom_range(0, 15)) << 1)) : ($urandom() & ~32'h1);
            flush_i    = 1'b1;
            flush_pc_i = start;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            next_cycle();
            exp_pc    = start;
            emitted   = 0;
            prev_hold = 1'b0;
            prev_instr = 32'h0;
            prev_pc    = 32'h0;
            for (int c = 0; c < 300; c++) begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
                if (prev_hold) begin
                    tests_run++;
                    if (instr_valid_o !== 1'b1 || instr_o !== prev_instr || pc_o !== prev_pc) begin
                        tests_failed++;
                        $display("FAIL rand%0d_hold_c%0d: got v=%b %h pc=%h expected 1 %h pc=%h",
                                 it, c, instr_valid_o, instr_o, pc_o, prev_instr, prev_pc);
                    end
                end
                if (instr_valid_o === 1'b1 && instr_ready_i) begin
                    exp_hw    = hw_at(exp_pc);
                    exp_comp  = exp_hw[1:0] != 2'b11;
                    exp_instr = exp_comp ? {16'h0000, exp_hw} : {hw_at(exp_pc + 32'd2), exp_hw};
                    tests_run++;
                    if (instr_o !== exp_instr || pc_o !== exp_pc || compressed_o !== exp_comp) begin
                        tests_failed++;
                        $display("FAIL rand%0d_instr%0d: got %h pc=%h c=%b expected %h pc=%h c=%b",
                                 it, emitted, instr_o, pc_o, compressed_o, exp_instr, exp_pc, exp_comp);
                    end
                    exp_pc = exp_pc + (exp_comp ? 32'd2 : 32'd4);
                    emitted++;
                end
                prev_hold  = (instr_valid_o === 1'b1) && !instr_ready_i;
                prev_instr = instr_o;
                prev_pc    = pc_o;
                next_cycle();
            end
            tests_run++;
            if (emitted < 40) begin
                tests_failed++;
                $display("FAIL rand%0d_progress: got %0d instructions expected at least 40", it, emitted);
            end
            $display("[TB] random run %0d from %h: %0d instructions", it, start, emitted);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        flush_pc_i    = 32'h0;
        mem_valid_i   = 1'b0;
        mem_rdata_i   = 32'h0;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        @(negedge clk_i);
        test_reset();
        test_word_stream();
        test_compressed_pair();
        test_straddle();
        test_flush();
        test_stall();
        test_reset_mid_stream();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_random(4);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
